// File: rtl/conv_asd.sv
// conv_asd: scans a 16-digit signed-digit word from MSD to LSD and records nonzero digit indices in K.
// Optional CONV_ASD_READBACK_EN: in IDLE, dataOut follows CSD[address] with one cycle of latency.
module conv_asd (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       weCsd,
    input  logic [3:0] address,
    input  logic [7:0] dataIn,
    output logic [7:0] dataOut,
    output logic [3:0] dataOutK,
    output logic       Zi,
    output logic       Zcsd,
    output logic       Zcnt,
    output logic       done,
    output logic       Load,
    output logic       reCsd,
    output logic       enable,
    output logic       enCnt,
    output logic       loadCnt,
    output logic       reK,
    output logic       weK
);

    typedef enum logic [2:0] {IDLE, INIT, READ, CHECK, NEXT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  kptr_q, kptr_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [3:0]  data_out_k_q, data_out_k_d;
    logic [7:0]  csd_q [16];
    logic [7:0]  csd_d [16];
    logic [3:0]  k_q [16];
    logic [3:0]  k_d [16];

    logic done_q, done_d;
    logic load_q, load_d;
    logic re_csd_q, re_csd_d;
    logic enable_q, enable_d;
    logic en_cnt_q, en_cnt_d;
    logic load_cnt_q, load_cnt_d;
    logic re_k_q, re_k_d;
    logic we_k_q, we_k_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        kptr_d       = kptr_q;
        data_out_d   = data_out_q;
        data_out_k_d = data_out_k_q;
        csd_d        = csd_q;
        k_d          = k_q;

        case (state_q)
            IDLE: begin
`ifdef CONV_ASD_READBACK_EN
                data_out_d = csd_q[address];
`endif
                if (start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                cnt_d   = 4'd15;
                kptr_d  = 5'd0;
                state_d = READ;
            end
            READ: begin
                data_out_d = csd_q[cnt_q];
                state_d    = CHECK;
            end
            CHECK: begin
                if (data_out_q != 8'd0 && kptr_q != 5'd16) begin
                    k_d[kptr_q[3:0]] = cnt_q;
                    kptr_d           = kptr_q + 5'd1;
                end
                state_d = NEXT;
            end
            NEXT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = READ;
                end
            end
            DONE: begin
                data_out_k_d = k_q[address];
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The host may only touch the digit store while no scan is in flight.
        if (weCsd && (state_q == IDLE || state_q == DONE)) begin
            csd_d[address] = dataIn;
        end

        // Strobes are registered from the next state so they line up with the state they describe.
        load_cnt_d = (state_d == INIT);
        re_csd_d   = (state_d == READ);
        load_d     = (state_d == READ);
        enable_d   = (state_d == CHECK);
        we_k_d     = (state_d == CHECK) && (data_out_d != 8'd0);
        en_cnt_d   = (state_d == NEXT) && (cnt_d != 4'd0);
        done_d     = (state_d == DONE);
        re_k_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            kptr_q       <= 5'd0;
            data_out_q   <= 8'd0;
            data_out_k_q <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                csd_q[i] <= 8'd0;
                k_q[i]   <= 4'd0;
            end
            done_q     <= 1'b0;
            load_q     <= 1'b0;
            re_csd_q   <= 1'b0;
            enable_q   <= 1'b0;
            en_cnt_q   <= 1'b0;
            load_cnt_q <= 1'b0;
            re_k_q     <= 1'b0;
            we_k_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            kptr_q       <= kptr_d;
            data_out_q   <= data_out_d;
            data_out_k_q <= data_out_k_d;
            csd_q        <= csd_d;
            k_q          <= k_d;
            done_q       <= done_d;
            load_q       <= load_d;
            re_csd_q     <= re_csd_d;
            enable_q     <= enable_d;
            en_cnt_q     <= en_cnt_d;
            load_cnt_q   <= load_cnt_d;
            re_k_q       <= re_k_d;
            we_k_q       <= we_k_d;
        end
    end

    assign dataOut  = data_out_q;
    assign dataOutK = data_out_k_q;
    assign Zi       = (data_out_q == 8'd0);
    assign Zcsd     = (kptr_q == 5'd0);
    assign Zcnt     = (cnt_q == 4'd0);
    assign done     = done_q;
    assign Load     = load_q;
    assign reCsd    = re_csd_q;
    assign enable   = enable_q;
    assign enCnt    = en_cnt_q;
    assign loadCnt  = load_cnt_q;
    assign reK      = re_k_q;
    assign weK      = we_k_q;

endmodule

// File: tb/tb_conv_asd.sv
// Testbench for conv_asd: timeline model of the scan checked every cycle, plus directed literal checks.
module tb_conv_asd;

    logic       clk;
    logic       reset;
    logic       start;
    logic       weCsd;
    logic [3:0] address;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic [3:0] dataOutK;
    logic       Zi, Zcsd, Zcnt, done, Load, reCsd, enable, enCnt, loadCnt, reK, weK;

    int checks   = 0;
    int failures = 0;
    int wek_count = 0;

    conv_asd dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .weCsd    (weCsd),
        .address  (address),
        .dataIn   (dataIn),
        .dataOut  (dataOut),
        .dataOutK (dataOutK),
        .Zi       (Zi),
        .Zcsd     (Zcsd),
        .Zcnt     (Zcnt),
        .done     (done),
        .Load     (Load),
        .reCsd    (reCsd),
        .enable   (enable),
        .enCnt    (enCnt),
        .loadCnt  (loadCnt),
        .reK      (reK),
        .weK      (weK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: mode 0 idle, 1 scanning (step t: 1 = init, then three steps per digit), 2 done.
    int         m_mode = 0;
    int         m_t = 0;
    int         m_kcnt = 0;
    logic [7:0] m_csd [16];
    logic [3:0] m_k [16];
    logic [7:0] m_dout = 8'd0;
    logic [3:0] m_doutk = 4'd0;
    int         m_d, m_ph;
    logic       in_scan;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_t = 0; m_kcnt = 0; m_dout = 8'd0; m_doutk = 4'd0;
            for (int i = 0; i < 16; i++) begin
                m_csd[i] = 8'd0;
                m_k[i]   = 4'd0;
            end
        end else begin
            case (m_mode)
                0: begin
`ifdef CONV_ASD_READBACK_EN
                    m_dout = m_csd[address];
`endif
                    if (weCsd) m_csd[address] = dataIn;
                    if (start) begin
                        m_mode = 1;
                        m_t    = 1;
                    end
                end
                1: begin
                    if (m_t == 1) begin
                        m_kcnt = 0;
                        m_t    = 2;
                    end else begin
                        m_d  = 15 - (m_t - 2) / 3;
                        m_ph = (m_t - 2) % 3;
                        if (m_ph == 0) begin
                            m_dout = m_csd[m_d];
                        end else if (m_ph == 1 && m_dout != 8'd0) begin
                            m_k[m_kcnt] = 4'(m_d);
                            m_kcnt++;
                        end
                        if (m_ph == 2 && m_d == 0) m_mode = 2;
                        else m_t++;
                    end
                end
                default: begin
                    m_doutk = m_k[address];
                    if (weCsd) m_csd[address] = dataIn;
                    if (!start) m_mode = 0;
                end
            endcase
        end

        #1;
        in_scan = (m_mode == 1) && (m_t >= 2);
        m_d  = in_scan ? 15 - (m_t - 2) / 3 : 0;
        m_ph = in_scan ? (m_t - 2) % 3 : 3;
        if (weK === 1'b1) wek_count++;
        checkOutput("loadCnt", 32'(loadCnt), 32'((m_mode == 1) && (m_t == 1)));
        checkOutput("reCsd",   32'(reCsd),   32'(m_ph == 0));
        checkOutput("Load",    32'(Load),    32'(m_ph == 0));
        checkOutput("enable",  32'(enable),  32'(m_ph == 1));
        checkOutput("weK",     32'(weK),     32'((m_ph == 1) && (m_dout != 8'd0)));
        checkOutput("enCnt",   32'(enCnt),   32'((m_ph == 2) && (m_d != 0)));
        checkOutput("done",    32'(done),    32'(m_mode == 2));
        checkOutput("reK",     32'(reK),     32'(m_mode == 2));
        checkOutput("Zcnt",    32'(Zcnt),    32'(!(in_scan && m_d != 0)));
        checkOutput("Zcsd",    32'(Zcsd),    32'(m_kcnt == 0));
        checkOutput("Zi",      32'(Zi),      32'(m_dout == 8'd0));
        checkOutput("dataOut", 32'(dataOut), 32'(m_dout));
        checkOutput("dataOutK", 32'(dataOutK), 32'(m_doutk));
    end

    task automatic applyStimulus(input logic s, input logic we, input logic [3:0] a, input logic [7:0] d);
        start   = s;
        weCsd   = we;
        address = a;
        dataIn  = d;
        @(negedge clk);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0);
        reset = 1'b0;
    endtask

    // Raises start and counts edges (the start-sampling edge is edge 1) until done is seen.
    task automatic runScan(output int edges);
        wek_count = 0;
        edges     = 0;
        start     = 1'b1;
        weCsd     = 1'b0;
        while (edges < 100) begin
            @(negedge clk);
            edges++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic readK(input logic [3:0] a, input logic [3:0] expected, input string name);
        applyStimulus(1'b1, 1'b0, a, 8'd0);
        checkOutput(name, 32'(dataOutK), 32'(expected));
    endtask

    int  edges;
    int  waited;

    initial begin
        reset = 1'b1; start = 1'b0; weCsd = 1'b0; address = 4'd0; dataIn = 8'd0;
        applyReset();
        checkOutput("rst_Zi",      32'(Zi),      32'd1);
        checkOutput("rst_Zcnt",    32'(Zcnt),    32'd1);
        checkOutput("rst_Zcsd",    32'(Zcsd),    32'd1);
        checkOutput("rst_dataOut", 32'(dataOut), 32'd0);
        checkOutput("rst_done",    32'(done),    32'd0);

        // Basic scan
        applyStimulus(1'b0, 1'b1, 4'd0, 8'h01);
        applyStimulus(1'b0, 1'b1, 4'd1, 8'h01);
        applyStimulus(1'b0, 1'b1, 4'd2, 8'h00);
        applyStimulus(1'b0, 1'b1, 4'd3, 8'h01);
        runScan(edges);
        checkOutput("basic_latency", 32'(edges), 32'd50);
        checkOutput("basic_wek",     32'(wek_count), 32'd3);
        checkOutput("basic_Zcsd",    32'(Zcsd), 32'd0);
        readK(4'd0, 4'd3, "basic_K0");
        readK(4'd1, 4'd1, "basic_K1");
        readK(4'd2, 4'd0, "basic_K2");
        applyStimulus(1'b1, 1'b0, 4'd0, 8'd0);
        checkOutput("basic_done_held", 32'(done), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0);
        checkOutput("basic_back_idle", 32'(done), 32'd0);

        // All-zero word
        applyReset();
        runScan(edges);
        checkOutput("zero_latency", 32'(edges), 32'd50);
        checkOutput("zero_wek",     32'(wek_count), 32'd0);
        checkOutput("zero_Zcsd",    32'(Zcsd), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0);

        // Negative digits
        applyStimulus(1'b0, 1'b1, 4'd15, 8'hFF);
        applyStimulus(1'b0, 1'b1, 4'd7,  8'h01);
        applyStimulus(1'b0, 1'b0, 4'd0,  8'h00);
        runScan(edges);
        checkOutput("neg_wek", 32'(wek_count), 32'd2);
        readK(4'd0, 4'd15, "neg_K0");
        readK(4'd1, 4'd7,  "neg_K1");
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0);

        // Write attempted during scan is ignored
        applyStimulus(1'b1, 1'b0, 4'd0, 8'd0);
        repeat (8) applyStimulus(1'b1, 1'b0, 4'd0, 8'd0);
        applyStimulus(1'b1, 1'b1, 4'd5, 8'h01);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
        waited = 0;
        while (done !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("wr_scan_finished", 32'(done), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0);
        runScan(edges);
        checkOutput("wr_rerun_wek", 32'(wek_count), 32'd2);
        readK(4'd2, 4'd0, "wr_rerun_K2");
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0);

        // Mid-scan reset
        start = 1'b1;
        waited = 0;
        while (reCsd !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("mid_reCsd_seen", 32'(reCsd), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0);
        reset = 1'b0;
        checkOutput("mid_done",    32'(done),    32'd0);
        checkOutput("mid_reCsd",   32'(reCsd),   32'd0);
        checkOutput("mid_Zcsd",    32'(Zcsd),    32'd1);
        repeat (4) applyStimulus(1'b0, 1'b0, 4'd0, 8'd0);
        checkOutput("mid_no_restart", 32'(loadCnt), 32'd0);
        checkOutput("mid_done_low",   32'(done),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
